// File: rtl/axi_slave_mem_pkg.sv
// Shared AXI encodings, FSM state types and the burst legality check for axi_slave_mem.
// Imported by the top and the RAM so every file agrees on the encodings.
package axi_slave_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rstate_e;

  // Reserved burst type, oversize beat, or a wrap length that is not a power of two.
  function automatic logic burst_illegal(input logic [1:0] burst, input logic [2:0] size,
                                         input logic [3:0] len, input logic [2:0] max_size);
    logic bad;
    bad = (burst == 2'b11) || (size > max_size);
    if (burst == BURST_WRAP && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}))
      bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/axi_slave_mem_ram.sv
// Simple dual-port word RAM: byte-enabled write port, registered read port.
// A read and a write to the same word in one cycle returns the old contents.
module axi_slave_mem_ram
  import axi_slave_mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int BW = DW / 8,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [BW-1:0] wr_be_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q;

  // Storage is deliberately not reset so contents survive a bus reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < BW; b++) begin
        if (wr_be_i[b]) mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 slave memory with independent single-outstanding read and write engines.
// Response is SLVERR for illegal bursts or W-channel protocol slips; data is still written.
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int WIDTH_ID    = 4,
  parameter int WIDTH_AD    = 32,
  parameter int WIDTH_DA    = 32,
  parameter int WIDTH_DS    = WIDTH_DA / 8,
  parameter int ADDR_LENGTH = 12
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [WIDTH_ID-1:0] AWID,
  input  logic [WIDTH_AD-1:0] AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [1:0]          AWLOCK,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [WIDTH_ID-1:0] WID,
  input  logic [WIDTH_DA-1:0] WDATA,
  input  logic [WIDTH_DS-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [WIDTH_ID-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [WIDTH_ID-1:0] ARID,
  input  logic [WIDTH_AD-1:0] ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [1:0]          ARLOCK,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [WIDTH_ID-1:0] RID,
  output logic [WIDTH_DA-1:0] RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int LG_DS  = $clog2(WIDTH_DS);
  localparam int RAM_AW = ADDR_LENGTH - LG_DS;

  function automatic logic [WIDTH_AD-1:0] next_addr(input logic [WIDTH_AD-1:0] a,
      input logic [2:0] size, input logic [3:0] len, input logic [1:0] burst);
    logic [WIDTH_AD-1:0] step, aligned, mask;
    step    = WIDTH_AD'(1) << size;
    aligned = a & ~(step - WIDTH_AD'(1));
    mask    = ((WIDTH_AD'(len) + WIDTH_AD'(1)) << size) - WIDTH_AD'(1);
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = (a & ~mask) | ((aligned + step) & mask);
      default:     next_addr = aligned + step;
    endcase
  endfunction

  logic unused_lock;
  assign unused_lock = ^{AWLOCK, ARLOCK};

  // Holds the READY outputs low until the first edge after reset release.
  logic ready_q;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // ---------------- write engine ----------------
  wstate_e               w_state_q, w_state_d;
  logic [WIDTH_ID-1:0]   awid_q;
  logic [WIDTH_AD-1:0]   waddr_q;
  logic [3:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic                  werr_q;
  logic                  aw_hs, w_hs, w_last_beat;

  assign aw_hs       = AWVALID & AWREADY;
  assign w_hs        = WVALID & WREADY;
  assign w_last_beat = (wcnt_q == wlen_q);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs)               w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (BREADY)              w_state_d = W_IDLE;
      default:                          w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (w_state_q)
      W_IDLE:  AWREADY = ready_q;
      W_DATA:  WREADY  = 1'b1;
      W_RESP:  BVALID  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awid_q <= '0; waddr_q <= '0; wlen_q <= '0; wcnt_q <= '0;
      wsize_q <= '0; wburst_q <= '0; werr_q <= 1'b0;
    end else if (aw_hs) begin
      awid_q   <= AWID;
      waddr_q  <= AWADDR;
      wlen_q   <= AWLEN;
      wsize_q  <= AWSIZE;
      wburst_q <= AWBURST;
      wcnt_q   <= '0;
      werr_q   <= burst_illegal(AWBURST, AWSIZE, AWLEN, 3'(LG_DS));
    end else if (w_hs) begin
      waddr_q <= next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
      wcnt_q  <= wcnt_q + 4'd1;
      if ((WLAST != w_last_beat) || (WID != awid_q)) werr_q <= 1'b1;
    end
  end

  assign BID   = awid_q;
  assign BRESP = (BVALID && werr_q) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read engine ----------------
  rstate_e               r_state_q, r_state_d;
  logic [WIDTH_ID-1:0]   arid_q;
  logic [WIDTH_AD-1:0]   raddr_q, raddr_nxt;
  logic [3:0]            rlen_q, rcnt_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;
  logic                  rerr_q;
  logic                  ar_hs, r_hs, rd_en;
  logic [RAM_AW-1:0]     rd_addr;

  assign ar_hs     = ARVALID & ARREADY;
  assign r_hs      = RVALID & RREADY;
  assign raddr_nxt = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)         r_state_d = R_FETCH;
      R_FETCH:                    r_state_d = R_DATA;
      R_DATA:  if (r_hs && RLAST) r_state_d = R_IDLE;
      default:                    r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    case (r_state_q)
      R_IDLE:  ARREADY = ready_q;
      R_DATA: begin
        RVALID = 1'b1;
        RLAST  = (rcnt_q == rlen_q);
      end
      default: ;
    endcase
  end

  // The next beat's RAM read launches on the accepting handshake, keeping beats back-to-back.
  assign rd_en   = (r_state_q == R_FETCH) || (r_hs && !RLAST);
  assign rd_addr = (r_state_q == R_FETCH) ? raddr_q[ADDR_LENGTH-1:LG_DS]
                                          : raddr_nxt[ADDR_LENGTH-1:LG_DS];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arid_q <= '0; raddr_q <= '0; rlen_q <= '0; rcnt_q <= '0;
      rsize_q <= '0; rburst_q <= '0; rerr_q <= 1'b0;
    end else if (ar_hs) begin
      arid_q   <= ARID;
      raddr_q  <= ARADDR;
      rlen_q   <= ARLEN;
      rsize_q  <= ARSIZE;
      rburst_q <= ARBURST;
      rcnt_q   <= '0;
      rerr_q   <= burst_illegal(ARBURST, ARSIZE, ARLEN, 3'(LG_DS));
    end else if (r_hs && !RLAST) begin
      raddr_q <= raddr_nxt;
      rcnt_q  <= rcnt_q + 4'd1;
    end
  end

  assign RID   = arid_q;
  assign RRESP = (RVALID && rerr_q) ? RESP_SLVERR : RESP_OKAY;

  axi_slave_mem_ram #(
    .DW (WIDTH_DA),
    .BW (WIDTH_DS),
    .AW (RAM_AW)
  ) u_ram (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .wr_en_i   (w_hs),
    .wr_addr_i (waddr_q[ADDR_LENGTH-1:LG_DS]),
    .wr_be_i   (WSTRB),
    .wr_data_i (WDATA),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (RDATA)
  );

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem: bursts, strobes, wrap, errors, stalls, reset.
module tb_axi_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [1:0]  AWLOCK, ARLOCK, AWBURST, ARBURST, BRESP, RRESP;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int checks = 0;
  int errors = 0;

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWLOCK(AWLOCK), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARLOCK(ARLOCK), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [0:3][31:0] data, input logic [3:0] strb,
                          input int last_beat, input logic [3:0] wid,
                          output logic [1:0] bresp, output logic [3:0] bid);
    int n;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWLOCK = 2'b01;
    AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL aw_timeout"); end
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WID = wid; WDATA = data[i]; WSTRB = strb; WLAST = (i == last_beat); WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) begin checks++; errors++; $display("FAIL w_timeout beat %0d", i); end
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    n = 0;
    while (BVALID !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL b_timeout"); end
    bresp = BRESP; bid = BID;
    tick();
    BREADY = 1'b0;
  endtask

  // stall_mask bit c drops RREADY on the c-th cycle after the first RVALID.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [15:0] stall_mask,
                         output logic [0:3][31:0] data, output logic [0:3][1:0] resp,
                         output int lat, output int rlast_bad, output int hold_bad,
                         output logic [3:0] rid);
    int n, cyc, beat;
    logic stalled;
    logic [31:0] held;
    data = '0; resp = '0; rlast_bad = 0; hold_bad = 0; stalled = 1'b0; held = '0;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARLOCK = 2'b01;
    ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL ar_timeout"); end
    tick();
    ARVALID = 1'b0;
    lat = 1;
    n = 0;
    while (RVALID !== 1'b1 && n < 50) begin tick(); lat++; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL rvalid_timeout"); end
    rid = RID;
    cyc = 0; beat = 0; n = 0;
    while (beat <= int'(len) && n < 100) begin
      RREADY = !stall_mask[cyc[3:0]];
      if (stalled && RDATA !== held) hold_bad++;
      if (RVALID === 1'b1 && RREADY) begin
        if (beat < 4) begin data[beat] = RDATA; resp[beat] = RRESP; end
        if (RLAST !== (beat == int'(len))) rlast_bad++;
        beat++;
      end
      stalled = !RREADY;
      held = RDATA;
      tick();
      cyc++; n++;
    end
    if (n >= 100) begin checks++; errors++; $display("FAIL r_beats_timeout"); end
    RREADY = 1'b0;
  endtask

  logic [1:0] bresp, bresp2;
  logic [3:0] bid, bid2, rid;
  logic [0:3][31:0] rd;
  logic [0:3][1:0] rr;
  int lat, rlb, hb;

  task automatic test_reset();
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWLOCK = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARLOCK = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (3) tick();
    checks++; if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0) begin errors++;
      $display("FAIL rst_ctrl got %b want 000000", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}); end
    checks++; if ({RDATA, RID, RRESP, BID, BRESP} !== '0) begin errors++;
      $display("FAIL rst_data got %h want 0", {RDATA, RID, RRESP, BID, BRESP}); end
    ARESET = 1'b0;
    #1;
    checks++; if (AWREADY !== 1'b0) begin errors++; $display("FAIL rel_awready_early got %b want 0", AWREADY); end
    tick();
    checks++; if ({AWREADY, ARREADY} !== 2'b11) begin errors++;
      $display("FAIL rel_ready got %b want 11", {AWREADY, ARREADY}); end
  endtask

  task automatic test_incr();
    do_write(4'd5, 32'h1000, 4'd3, 3'd2, 2'b01, {32'h11, 32'h22, 32'h33, 32'h44}, 4'hF, 3, 4'd5, bresp, bid);
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL incr_bresp got %b want 00", bresp); end
    checks++; if (bid !== 4'd5) begin errors++; $display("FAIL incr_bid got %0d want 5", bid); end
    do_read(4'd6, 32'h1000, 4'd3, 3'd2, 2'b01, 16'h0, rd, rr, lat, rlb, hb, rid);
    checks++; if (rd !== {32'h11, 32'h22, 32'h33, 32'h44}) begin errors++;
      $display("FAIL incr_rdata got %h want 00000011000000220000003300000044", rd); end
    checks++; if (rr !== 8'h00) begin errors++; $display("FAIL incr_rresp got %h want 00", rr); end
    checks++; if (rlb !== 0) begin errors++; $display("FAIL incr_rlast got %0d bad beats want 0", rlb); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL incr_latency got %0d want 2", lat); end
    checks++; if (rid !== 4'd6) begin errors++; $display("FAIL incr_rid got %0d want 6", rid); end
  endtask

  task automatic test_unaligned();
    do_write(4'd1, 32'h1000, 4'd0, 3'd2, 2'b01, {32'h0, 32'h0, 32'h0, 32'h0}, 4'hF, 0, 4'd1, bresp, bid);
    do_write(4'd1, 32'h1001, 4'd0, 3'd2, 2'b01, {32'hAABBCCDD, 32'h0, 32'h0, 32'h0}, 4'b1110, 0, 4'd1, bresp, bid);
    do_read(4'd1, 32'h1000, 4'd0, 3'd2, 2'b01, 16'h0, rd, rr, lat, rlb, hb, rid);
    checks++; if (rd[0] !== 32'hAABBCC00) begin errors++;
      $display("FAIL unaligned got %h want aabbcc00", rd[0]); end
  endtask

  task automatic test_wrap();
    do_write(4'd2, 32'h1030, 4'd3, 3'd2, 2'b01, {32'hA0, 32'hA1, 32'hA2, 32'hA3}, 4'hF, 3, 4'd2, bresp, bid);
    do_read(4'd2, 32'h1038, 4'd3, 3'd2, 2'b10, 16'h0, rd, rr, lat, rlb, hb, rid);
    checks++; if (rd !== {32'hA2, 32'hA3, 32'hA0, 32'hA1}) begin errors++;
      $display("FAIL wrap_rdata got %h want 000000a2000000a3000000a0000000a1", rd); end
    checks++; if (rr !== 8'h00 || rlb !== 0) begin errors++;
      $display("FAIL wrap_resp got rresp %h rlast_bad %0d want 00 0", rr, rlb); end
  endtask

  task automatic test_errors();
    do_write(4'd9, 32'h1200, 4'd3, 3'd2, 2'b01, {32'hC0, 32'hC1, 32'hC2, 32'hC3}, 4'hF, 1, 4'd9, bresp, bid);
    checks++; if (bresp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp got %b want 10", bresp); end
    checks++; if (bid !== 4'd9) begin errors++; $display("FAIL early_wlast_bid got %0d want 9", bid); end
    do_read(4'd3, 32'h1200, 4'd3, 3'd2, 2'b01, 16'h0, rd, rr, lat, rlb, hb, rid);
    checks++; if (rd[3] !== 32'hC3) begin errors++; $display("FAIL early_wlast_data got %h want 000000c3", rd[3]); end
    do_write(4'd2, 32'h1300, 4'd0, 3'd3, 2'b01, {32'h5, 32'h0, 32'h0, 32'h0}, 4'hF, 0, 4'd2, bresp, bid);
    checks++; if (bresp !== 2'b10) begin errors++; $display("FAIL oversize_bresp got %b want 10", bresp); end
    do_write(4'd4, 32'h1304, 4'd0, 3'd2, 2'b01, {32'h6, 32'h0, 32'h0, 32'h0}, 4'hF, 0, 4'd5, bresp, bid);
    checks++; if (bresp !== 2'b10) begin errors++; $display("FAIL wid_bresp got %b want 10", bresp); end
    do_read(4'd3, 32'h1200, 4'd0, 3'd2, 2'b11, 16'h0, rd, rr, lat, rlb, hb, rid);
    checks++; if (rr[0] !== 2'b10 || rd[0] !== 32'hC0) begin errors++;
      $display("FAIL burst3_read got resp %b data %h want 10 000000c0", rr[0], rd[0]); end
    do_read(4'd3, 32'h1200, 4'd2, 3'd2, 2'b10, 16'h0, rd, rr, lat, rlb, hb, rid);
    checks++; if (rr[0:2] !== 6'b101010 || rlb !== 0) begin errors++;
      $display("FAIL wrap_len2 got resp %b rlast_bad %0d want 101010 0", rr[0:2], rlb); end
  endtask

  task automatic test_stall_concurrent();
    fork
      do_read(4'd7, 32'h1000, 4'd3, 3'd2, 2'b01, 16'b0110, rd, rr, lat, rlb, hb, rid);
      do_write(4'd3, 32'h0800, 4'd1, 3'd2, 2'b01, {32'h5555AAAA, 32'h12345678, 32'h0, 32'h0},
               4'hF, 1, 4'd3, bresp2, bid2);
    join
    checks++; if (rd !== {32'hAABBCC00, 32'h22, 32'h33, 32'h44}) begin errors++;
      $display("FAIL stall_rdata got %h want aabbcc00000000220000003300000044", rd); end
    checks++; if (hb !== 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", hb); end
    checks++; if (bresp2 !== 2'b00 || bid2 !== 4'd3) begin errors++;
      $display("FAIL concurrent_b got resp %b id %0d want 00 3", bresp2, bid2); end
    do_read(4'd0, 32'h0800, 4'd1, 3'd2, 2'b01, 16'h0, rd, rr, lat, rlb, hb, rid);
    checks++; if (rd[0:1] !== {32'h5555AAAA, 32'h12345678}) begin errors++;
      $display("FAIL concurrent_data got %h want 5555aaaa12345678", rd[0:1]); end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    ARID = 4'd8; ARADDR = 32'h1030; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    ARVALID = 1'b0;
    n = 0;
    while (RVALID !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL mid_rvalid_timeout"); end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    ARESET = 1'b1;
    #1;
    checks++; if ({RVALID, ARREADY} !== 2'b00) begin errors++;
      $display("FAIL mid_rst_outputs got %b want 00", {RVALID, ARREADY}); end
    tick();
    ARESET = 1'b0;
    tick();
    checks++; if ({RVALID, ARREADY} !== 2'b01) begin errors++;
      $display("FAIL mid_rel got rvalid,arready %b want 01", {RVALID, ARREADY}); end
    do_read(4'd8, 32'h1030, 4'd3, 3'd2, 2'b01, 16'h0, rd, rr, lat, rlb, hb, rid);
    checks++; if (rd !== {32'hA0, 32'hA1, 32'hA2, 32'hA3}) begin errors++;
      $display("FAIL mem_intact got %h want 000000a0000000a1000000a2000000a3", rd); end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_unaligned();
    test_wrap();
    test_errors();
    test_stall_concurrent();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter WIDTH_ID, default 4, AXI ID width.
REQ-002 SHALL have parameter WIDTH_AD, default 32, address width.
REQ-003 SHALL have parameter WIDTH_DA, default 32, data width (32/64/128).
REQ-004 SHALL have parameter WIDTH_DS, default WIDTH_DA/8, strobe width.
REQ-005 SHALL have parameter ADDR_LENGTH, default 12, memory size in bytes is 2^ADDR_LENGTH.
REQ-006 SHALL have ports ACLK (input, 1, clock) and ARESET (input, 1, reset). One clock; reset is asynchronous and active-high.
REQ-007 SHALL have the AW channel as inputs AWID[WIDTH_ID], AWADDR[WIDTH_AD], AWLEN[4], AWLOCK[2], AWSIZE[3], AWBURST[2] and AWVALID, plus output AWREADY.
REQ-008 SHALL have the W channel as inputs WID[WIDTH_ID], WDATA[WIDTH_DA], WSTRB[WIDTH_DS], WLAST and WVALID, plus output WREADY.
REQ-009 SHALL have the B channel as outputs BID[WIDTH_ID], BRESP[2] and BVALID, plus input BREADY.
REQ-010 SHALL have the AR channel as inputs ARID, ARADDR, ARLEN[4], ARLOCK[2], ARSIZE[3], ARBURST[2] and ARVALID, plus output ARREADY.
REQ-011 SHALL have the R channel as outputs RID, RDATA[WIDTH_DA], RRESP[2], RLAST and RVALID, plus input RREADY.

Function
REQ-012 SHALL act as the AXI3 slave memory consumed by the DMA/BFM master, with independent, concurrent read and write engines, one outstanding transaction each.
REQ-013 The write FSM SHALL have states W_IDLE (AWREADY=1), W_DATA (WREADY=1) and W_RESP (BVALID=1).
- W_IDLE to W_DATA on AW handshake.
- W_DATA to W_RESP on the W handshake of beat AWLEN+1.
- W_RESP to W_IDLE on BREADY.
REQ-014 Each W handshake SHALL write WDATA bytes whose WSTRB bit is 1 at the word address (addr>>log2(WIDTH_DS)), modulo 2^ADDR_LENGTH; upper address bits SHALL be ignored.
REQ-015 Address update after each beat:
- INCR: next = (addr aligned to 2^AxSIZE) + 2^AxSIZE.
- FIXED: unchanged.
- WRAP: wraps within an aligned (AxLEN+1)*2^AxSIZE window.
REQ-016 BRESP SHALL be SLVERR (2'b10) if any of the following occurred, else OKAY; data SHALL be written regardless:
- WLAST mismatched the beat count on any beat.
- WID differed from the captured AWID.
- AWBURST==2'b11.
- AWSIZE > log2(WIDTH_DS).
- WRAP with AWLEN not in {1,3,7,15}.
REQ-017 BID SHALL equal the captured AWID.
REQ-018 The read FSM SHALL have states R_IDLE (ARREADY=1), R_FETCH and R_DATA (RVALID=1).
- R_IDLE to R_FETCH on AR handshake.
- R_FETCH to R_DATA after one cycle.
- R_DATA to R_IDLE on handshake with RLAST=1.
REQ-019 First RVALID SHALL assert 2 cycles after the AR handshake edge. Subsequent beats SHALL be back-to-back while RREADY=1: the next-address RAM read is issued on the handshake cycle.
REQ-020 RDATA/RID/RRESP/RLAST SHALL hold stable while RVALID=1 and RREADY=0.
REQ-021 RLAST SHALL be 1 exactly on beat ARLEN+1.
REQ-022 RRESP SHALL be SLVERR on every beat for the illegal AR conditions of REQ-016, OKAY otherwise.
REQ-023 Narrow reads SHALL return the full data word; the master selects lanes.
REQ-024 On a simultaneous read and write of the same word in one cycle, the read SHALL return the old data.
REQ-025 AWLOCK/ARLOCK SHALL be ignored (exclusive access returns OKAY, never EXOKAY).

Reset
REQ-026 While ARESET=1, all outputs SHALL be 0 and both FSMs SHALL be IDLE; AWREADY/ARREADY SHALL rise on the first ACLK edge after release.
REQ-027 Reset mid-burst SHALL abandon the transaction with no response issued; memory contents SHALL NOT be reset.

Structure
REQ-028 Burst encodings (FIXED/INCR/WRAP), response codes (OKAY/EXOKAY/SLVERR/DECERR) and FSM state encodings SHALL live in the shared AXI package/defines file.
REQ-029 Storage SHALL be a sub-module axi_slave_mem_ram:
- simple dual-port (one byte-enabled write port, one synchronous read port);
- depth 2^ADDR_LENGTH/WIDTH_DS words.

Verification
REQ-030 INCR write, AWADDR=0x1000, AWLEN=3, AWSIZE=2, data 0x11..0x44, then read back with the same parameters: four OKAY beats with matching data, RLAST on beat 4, first RVALID 2 cycles after ARREADY handshake.
REQ-031 Unaligned write AWADDR=0x1001, WSTRB=4'b1110, data 0xAABBCCDD over 0x00000000: readback is 0xAABBCC00.
REQ-032 WRAP read ARADDR=0x1038, ARLEN=3, ARSIZE=2: beat addresses 0x1038, 0x103C, 0x1030, 0x1034.
REQ-033 Write with WLAST on beat 2 of AWLEN=3: all 4 beats accepted, BRESP=SLVERR, BID=AWID; AWSIZE=3 on a 32-bit bus also yields SLVERR.
REQ-034 Read with RREADY toggling 1,0,0,1: RDATA held stable through stall; concurrent write to the other half of memory completes independently.
REQ-035 ARESET pulse during beat 2 of a 4-beat read: RVALID=0, ARREADY=1 on the first edge after release; earlier-written memory data is intact.
